// File: rtl/pulse_width_sweeper.sv
// ----------------------------------------------------------------------------
// pulse_width_sweeper
//
// Sweeps a pulse-width value between a configurable minimum and maximum.
// The result drives the pulse_width input of a pulse tone generator. The
// sweep shape is a triangle (UP <-> DOWN). Optionally it can be a one-shot
// (UP -> HOLD at max). Steps are paced by a divider that counts sample_tick
// strobes. Configuration is double-buffered: cfg_load writes a shadow set.
// The shadow set becomes active at a safe point: the next step event, or at
// once while the sweep is idle or holding.
//
// Build option:
//   PULSE_WIDTH_SWEEPER_ONESHOT_EN  defined   -> mode selects triangle/one-shot
//                                   undefined -> triangle only, mode ignored
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_tick  in   one-cycle sample-rate strobe
//   enable       in   run the sweep when high, idle when low
//   retrigger    in   one-cycle strobe, restart the sweep from min
//   mode         in   0 = triangle, 1 = one-shot
//   cfg_load     in   one-cycle strobe capturing cfg_* into the shadow set
//   cfg_min      in   [PULSEWIDTH_BITS] sweep lower bound
//   cfg_max      in   [PULSEWIDTH_BITS] sweep upper bound
//   cfg_step     in   [PULSEWIDTH_BITS] increment per step
//   cfg_rate     in   [RATE_BITS] extra sample_ticks between steps
//   pulse_width  out  [PULSEWIDTH_BITS] registered sweep value
//   sweep_up     out  1 while sweeping upward
//   step_strobe  out  one-cycle pulse per applied step
//   cfg_ack      out  one-cycle pulse when the shadow set becomes active
// ----------------------------------------------------------------------------
module pulse_width_sweeper #(
    parameter int PULSEWIDTH_BITS = 12,
    parameter int RATE_BITS       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_tick,
    input  logic                       enable,
    input  logic                       retrigger,
    input  logic                       mode,
    input  logic                       cfg_load,
    input  logic [PULSEWIDTH_BITS-1:0] cfg_min,
    input  logic [PULSEWIDTH_BITS-1:0] cfg_max,
    input  logic [PULSEWIDTH_BITS-1:0] cfg_step,
    input  logic [RATE_BITS-1:0]       cfg_rate,
    output logic [PULSEWIDTH_BITS-1:0] pulse_width,
    output logic                       sweep_up,
    output logic                       step_strobe,
    output logic                       cfg_ack
);

    localparam int PW = PULSEWIDTH_BITS;
    localparam logic [RATE_BITS-1:0] RATE_ONE = RATE_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_pw;
    logic                  r_sweep_up;
    logic                  r_step_strobe;
    logic                  r_cfg_ack;
    logic [RATE_BITS-1:0]  r_div;
    logic                  r_pending;
    logic                  r_en_d;

    // Shadow (written by cfg_load) and active (used by the sweep) sets.
    logic [PW-1:0]         r_sh_min, r_sh_max, r_sh_step;
    logic [RATE_BITS-1:0]  r_sh_rate;
    logic [PW-1:0]         r_act_min, r_act_max, r_act_step;
    logic [RATE_BITS-1:0]  r_act_rate;

    logic                  w_oneshot;
    logic                  w_start;
    logic                  w_running;
    logic                  w_step_evt;
    logic                  w_copy;
    logic [PW-1:0]         w_min, w_max, w_step;
    logic [PW:0]           w_sum;
    logic [PW:0]           w_diff;
    logic                  w_up_sat;
    logic                  w_dn_sat;
    logic                  w_degenerate;

`ifdef PULSE_WIDTH_SWEEPER_ONESHOT_EN
    assign w_oneshot = mode;
`else
    // One-shot support is compiled out, so mode has no effect.
    assign w_oneshot = mode & 1'b0;
`endif

    // Control decode and saturating step arithmetic.
    always_comb begin
        w_start    = enable & (~r_en_d | retrigger);
        w_running  = (r_state == ST_UP) | (r_state == ST_DOWN);
        // A restart outranks a step landing in the same cycle.
        w_step_evt = enable & ~w_start & w_running & sample_tick &
                     (r_div == r_act_rate);
        w_copy     = r_pending & (w_start | w_step_evt |
                     (r_state == ST_IDLE) | (r_state == ST_HOLD));
        // Values in force for this cycle: a copy applies before it is used.
        w_min      = w_copy ? r_sh_min  : r_act_min;
        w_max      = w_copy ? r_sh_max  : r_act_max;
        w_step     = w_copy ? r_sh_step : r_act_step;
        // One extra bit so the sum cannot wrap and the difference shows a borrow.
        w_sum      = {1'b0, r_pw} + {1'b0, w_step};
        w_diff     = {1'b0, r_pw} - {1'b0, w_step};
        w_up_sat   = (w_sum >= {1'b0, w_max});
        w_dn_sat   = w_diff[PW] | (w_diff[PW-1:0] <= w_min);
        w_degenerate = (w_min >= w_max);
    end

    // Sweep state machine, divider, configuration buffering and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pw          <= '0;
            r_sweep_up    <= 1'b0;
            r_step_strobe <= 1'b0;
            r_cfg_ack     <= 1'b0;
            r_div         <= '0;
            r_pending     <= 1'b0;
            r_en_d        <= 1'b0;
            r_sh_min      <= '0;
            r_sh_max      <= '0;
            r_sh_step     <= '0;
            r_sh_rate     <= '0;
            r_act_min     <= '0;
            r_act_max     <= '0;
            r_act_step    <= '0;
            r_act_rate    <= '0;
        end else begin
            r_en_d        <= enable;
            r_cfg_ack     <= w_copy;
            r_step_strobe <= 1'b0;

            // A load in the copy cycle wins: the new shadow stays pending.
            if (cfg_load) begin
                r_sh_min  <= cfg_min;
                r_sh_max  <= cfg_max;
                r_sh_step <= cfg_step;
                r_sh_rate <= cfg_rate;
                r_pending <= 1'b1;
            end else if (w_copy) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end

            if (w_copy) begin
                r_act_min  <= r_sh_min;
                r_act_max  <= r_sh_max;
                r_act_step <= r_sh_step;
                r_act_rate <= r_sh_rate;
            end else begin
                r_act_min  <= r_act_min;
                r_act_max  <= r_act_max;
                r_act_step <= r_act_step;
                r_act_rate <= r_act_rate;
            end

            if (!enable) begin
                r_state    <= ST_IDLE;
                r_div      <= '0;
                r_pw       <= w_min;
                r_sweep_up <= 1'b0;
            end else if (w_start) begin
                r_state    <= ST_UP;
                r_div      <= '0;
                r_pw       <= w_min;
                r_sweep_up <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_IDLE;
                        r_pw       <= w_min;
                        r_sweep_up <= 1'b0;
                    end
                    ST_UP, ST_DOWN: begin
                        if (sample_tick) begin
                            r_div <= w_step_evt ? '0 : (r_div + RATE_ONE);
                        end else begin
                            r_div <= r_div;
                        end

                        if (w_degenerate) begin
                            // Empty range: park at min, no strobe.
                            r_pw <= w_min;
                        end else if (w_step_evt) begin
                            r_step_strobe <= 1'b1;
                            if (w_step == '0) begin
                                r_pw <= r_pw;
                            end else if (r_state == ST_UP) begin
                                if (w_up_sat) begin
                                    r_pw       <= w_max;
                                    // mode is only looked at here, at the max boundary.
                                    r_state    <= w_oneshot ? ST_HOLD : ST_DOWN;
                                    r_sweep_up <= 1'b0;
                                end else begin
                                    r_pw <= w_sum[PW-1:0];
                                end
                            end else begin
                                if (w_dn_sat) begin
                                    r_pw       <= w_min;
                                    r_state    <= ST_UP;
                                    r_sweep_up <= 1'b1;
                                end else begin
                                    r_pw <= w_diff[PW-1:0];
                                end
                            end
                        end else begin
                            r_pw <= r_pw;
                        end
                    end
                    ST_HOLD: begin
                        r_state    <= ST_HOLD;
                        r_pw       <= w_max;
                        r_sweep_up <= 1'b0;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_pw       <= w_min;
                        r_sweep_up <= 1'b0;
                        r_div      <= '0;
                    end
                endcase
            end
        end
    end

    assign pulse_width = r_pw;
    assign sweep_up    = r_sweep_up;
    assign step_strobe = r_step_strobe;
    assign cfg_ack     = r_cfg_ack;

endmodule

// File: tb/tb_pulse_width_sweeper.sv
module tb_pulse_width_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        enable;
    logic        retrigger;
    logic        mode;
    logic        cfg_load;
    logic [11:0] cfg_min;
    logic [11:0] cfg_max;
    logic [11:0] cfg_step;
    logic [15:0] cfg_rate;
    logic [11:0] pulse_width;
    logic        sweep_up;
    logic        step_strobe;
    logic        cfg_ack;

    int n_assert = 0;
    int n_fail   = 0;

    pulse_width_sweeper #(.PULSEWIDTH_BITS(12), .RATE_BITS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .enable      (enable),
        .retrigger   (retrigger),
        .mode        (mode),
        .cfg_load    (cfg_load),
        .cfg_min     (cfg_min),
        .cfg_max     (cfg_max),
        .cfg_step    (cfg_step),
        .cfg_rate    (cfg_rate),
        .pulse_width (pulse_width),
        .sweep_up    (sweep_up),
        .step_strobe (step_strobe),
        .cfg_ack     (cfg_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int mn, input int mx, input int st, input int rt);
        cfg_min  = 12'(mn);
        cfg_max  = 12'(mx);
        cfg_step = 12'(st);
        cfg_rate = 16'(rt);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        int exp_pw [7];
        bit exp_up [7];
        int tri_pw [5];

        rst_n = 1'b0; sample_tick = 1'b0; enable = 1'b0; retrigger = 1'b0;
        mode = 1'b0; cfg_load = 1'b0;
        cfg_min = 12'd0; cfg_max = 12'd0; cfg_step = 12'd0; cfg_rate = 16'd0;
        #12;
        chk("rst_pw", pulse_width, 0);
        chk("rst_up", sweep_up, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_ack", cfg_ack, 0);
        @(negedge clk) rst_n = 1'b1;

        // Triangle 100..130 step 10, tick every cycle.
        load(100, 130, 10, 0);
        chk("ack_early", cfg_ack, 0);
        tick();
        chk("ack_idle_copy", cfg_ack, 1);
        chk("idle_pw_min", pulse_width, 100);
        enable = 1'b1; sample_tick = 1'b1;
        tick();
        chk("start_pw", pulse_width, 100);
        chk("start_up", sweep_up, 1);
        chk("start_strobe", step_strobe, 0);
        exp_pw = '{110, 120, 130, 120, 110, 100, 110};
        exp_up = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("tri_pw", pulse_width, exp_pw[i]);
            chk("tri_up", sweep_up, exp_up[i]);
            chk("tri_strobe", step_strobe, 1);
        end

        // Full range with saturation, step every 3rd tick.
        enable = 1'b0;
        tick();
        chk("disable_pw", pulse_width, 100);
        chk("disable_up", sweep_up, 0);
        load(0, 4095, 3000, 2);
        tick();
        chk("sat_idle_pw", pulse_width, 0);
        enable = 1'b1;
        tick();
        tri_pw = '{0, 3000, 4095, 1095, 0};
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("sat_pw", pulse_width, tri_pw[k / 3]);
            chk("sat_strobe", step_strobe, (k % 3 == 0) ? 1 : 0);
        end

        // New max loaded mid-sweep applies at the next step event.
        enable = 1'b0;
        tick();
        load(0, 100, 10, 3);
        tick();
        enable = 1'b1;
        tick();
        repeat (8) tick();
        chk("mid_pw20", pulse_width, 20);
        cfg_max = 12'd50; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("mid_ack_load", cfg_ack, 0);
        chk("mid_pw_load", pulse_width, 20);
        tick(); tick();
        chk("mid_ack_wait", cfg_ack, 0);
        chk("mid_pw_wait", pulse_width, 20);
        tick();
        chk("mid_ack_step", cfg_ack, 1);
        chk("mid_strobe_step", step_strobe, 1);
        chk("mid_pw30", pulse_width, 30);
        tick();
        chk("mid_ack_once", cfg_ack, 0);
        repeat (3) tick();
        chk("mid_pw40", pulse_width, 40);
        repeat (4) tick();
        chk("mid_pw50", pulse_width, 50);
        chk("mid_turn_up", sweep_up, 0);
        repeat (4) tick();
        chk("mid_pw_down", pulse_width, 40);

        // Load colliding with the copy: the second set stays pending.
        enable = 1'b0;
        tick();
        cfg_min = 12'd7; cfg_max = 12'd60; cfg_step = 12'd1; cfg_rate = 16'd0;
        cfg_load = 1'b1;
        tick();
        cfg_min = 12'd9;
        tick();
        cfg_load = 1'b0;
        chk("coll_ack1", cfg_ack, 1);
        chk("coll_pw_a", pulse_width, 7);
        tick();
        chk("coll_ack2", cfg_ack, 1);
        chk("coll_pw_b", pulse_width, 9);
        tick();
        chk("coll_ack_done", cfg_ack, 0);

        // Step of zero: strobe pulses, value and direction unchanged.
        load(0, 100, 0, 0);
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("zstep_strobe", step_strobe, 1);
        chk("zstep_pw", pulse_width, 0);
        chk("zstep_up", sweep_up, 1);

        // min >= max: parked at min, no strobe.
        enable = 1'b0;
        tick();
        load(50, 50, 10, 0);
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("degen_pw", pulse_width, 50);
        chk("degen_strobe", step_strobe, 0);

        // mode = 1 : one-shot when compiled in, otherwise ignored.
        enable = 1'b0;
        tick();
        load(0, 20, 10, 0);
        tick();
        mode = 1'b1; enable = 1'b1;
        tick();
        tick();
        tick();
        chk("os_pw_max", pulse_width, 20);
        chk("os_up_max", sweep_up, 0);
`ifdef PULSE_WIDTH_SWEEPER_ONESHOT_EN
        repeat (10) tick();
        chk("os_hold_pw", pulse_width, 20);
        chk("os_hold_strobe", step_strobe, 0);
        retrigger = 1'b1;
        tick();
        retrigger = 1'b0;
        chk("os_retrig_pw", pulse_width, 0);
        chk("os_retrig_up", sweep_up, 1);
`else
        tick();
        chk("tri_only_pw", pulse_width, 10);
        chk("tri_only_up", sweep_up, 0);
`endif

        // Asynchronous reset between edges mid-sweep.
        tick(); tick();
        #3;
        rst_n = 1'b0; enable = 1'b0;
        #1;
        chk("arst_pw", pulse_width, 0);
        chk("arst_up", sweep_up, 0);
        chk("arst_strobe", step_strobe, 0);
        chk("arst_ack", cfg_ack, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_pw", pulse_width, 0);
        chk("post_rst_up", sweep_up, 0);
        chk("post_rst_ack", cfg_ack, 0);
        enable = 1'b1;
        tick();
        chk("resume_up", sweep_up, 1);
        chk("resume_pw", pulse_width, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
